// File: rtl/des_link_ctrl_if.sv
// des_link_ctrl_if
// Bundles the transmit-request, link-word and receive-consumer signals of
// the serdes link scheduler.
//   master : des_link_ctrl side (drives grants, transmit word, receive head)
//   slave  : requesters / link / receive consumer side
// Signals:
//   req_en, req_valid, req_data : per-requester enable, pending flag, word
//   req_ready                   : one-hot grant
//   des_din / des_dout          : transmit word to link / assembled receive word
//   tx_active, tx_id            : current frame owner
//   rx_enable, rx_ready         : receive capture enable, consumer pop
//   rx_valid, rx_data           : receive buffer head
//   rx_drop_cnt                 : saturating overflow drop count
interface des_link_ctrl_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_en;
    logic [N_REQ-1:0]    req_valid;
    logic [64*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic [63:0]         des_din;
    logic [63:0]         des_dout;
    logic                tx_active;
    logic [ID_W-1:0]     tx_id;
    logic                rx_enable;
    logic                rx_valid;
    logic [63:0]         rx_data;
    logic                rx_ready;
    logic [7:0]          rx_drop_cnt;

    modport master (
        input  req_en, req_valid, req_data, des_dout, rx_enable, rx_ready,
        output req_ready, des_din, tx_active, tx_id, rx_valid, rx_data, rx_drop_cnt
    );

    modport slave (
        output req_en, req_valid, req_data, des_dout, rx_enable, rx_ready,
        input  req_ready, des_din, tx_active, tx_id, rx_valid, rx_data, rx_drop_cnt
    );
endinterface

// File: rtl/des_link_ctrl.sv
// des_link_ctrl
// Frame scheduler and round-robin arbiter for the 64-bit serdes link.
// An 8-cycle frame counter (fc) mirrors the link's phase counter. At fc==7 a
// round-robin arbiter picks one enabled, valid requester; on the 7->0 edge
// its word is loaded onto des_din and held for the whole frame. On the edge
// leaving fc==4 the completed inbound word is pushed into a 2-entry receive
// FIFO with a valid/ready consumer port and a saturating drop counter.
// Ports:
//   in_clk : clock shared with the link block
//   rst    : asynchronous, active-high reset
//   bus    : des_link_ctrl_if.master (requesters, link words, rx consumer)
module des_link_ctrl #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic            in_clk,
    input  logic            rst,
    des_link_ctrl_if.master bus
);

    localparam logic [2:0]    FC_GRANT   = 3'd7;
    localparam logic [2:0]    FC_CAPTURE = 3'd4;
    localparam logic [ID_W:0] N_REQ_W    = (ID_W+1)'(N_REQ);
    localparam logic [ID_W:0] ONE_W      = (ID_W+1)'(1);

    // Registered state
    logic [2:0]      fc_q,          fc_d;
    logic [ID_W-1:0] rr_q,          rr_d;
    logic [63:0]     des_din_q,     des_din_d;
    logic [ID_W-1:0] tx_id_q,       tx_id_d;
    logic            tx_active_q,   tx_active_d;
    logic [1:0]      rx_cnt_q,      rx_cnt_d;
    logic [63:0]     rx_mem0_q,     rx_mem0_d;
    logic [63:0]     rx_mem1_q,     rx_mem1_d;
    logic            rx_valid_q,    rx_valid_d;
    logic [7:0]      rx_drop_cnt_q, rx_drop_cnt_d;

    // Arbiter signals
    logic [N_REQ-1:0] eligible_s;
    logic             win_found_s;
    logic [ID_W-1:0]  win_id_s;
    logic [ID_W:0]    cand_ext_s;
    logic [ID_W-1:0]  cand_s;
    logic             hit_s;
    logic [63:0]      win_data_s;
    logic             grant_window_s;
    logic [N_REQ-1:0] req_ready_s;
    logic [ID_W:0]    next_rr_ext_s;

    // Receive signals
    logic rx_pop_s;
    logic rx_try_s;
    logic rx_full_s;
    logic rx_push_s;
    logic rx_drop_s;

    // Round-robin search over eligible requesters starting at rr_q.
    always_comb begin
        eligible_s  = bus.req_valid & bus.req_en;
        win_found_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        cand_ext_s  = {(ID_W+1){1'b0}};
        cand_s      = {ID_W{1'b0}};
        hit_s       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // rr_q + k stays below 2*N_REQ, so one conditional subtract wraps it
            cand_ext_s  = {1'b0, rr_q} + (ID_W+1)'(k);
            cand_ext_s  = (cand_ext_s >= N_REQ_W) ? (cand_ext_s - N_REQ_W) : cand_ext_s;
            cand_s      = cand_ext_s[ID_W-1:0];
            hit_s       = !win_found_s && eligible_s[cand_s];
            win_id_s    = hit_s ? cand_s : win_id_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    // Winner word mux, one-hot grant and next round-robin pointer.
    always_comb begin
        win_data_s = 64'h0;
        for (int k = 0; k < N_REQ; k++) begin
            win_data_s = (win_id_s == ID_W'(k)) ? bus.req_data[64*k +: 64] : win_data_s;
        end
        // Grant is masked during reset: fc sits at 7 then, but no edge will
        // ever complete the handshake, so a requester must not see ready.
        grant_window_s = (fc_q == FC_GRANT) && !rst;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_s[k] = grant_window_s && win_found_s && (win_id_s == ID_W'(k));
        end
        next_rr_ext_s = {1'b0, win_id_s} + ONE_W;
        next_rr_ext_s = (next_rr_ext_s >= N_REQ_W) ? {(ID_W+1){1'b0}} : next_rr_ext_s;
    end

    // Frame counter and transmit-side next state; transmit outputs change only
    // on the fc 7->0 edge so they stay stable for the whole frame.
    always_comb begin
        fc_d        = fc_q + 3'd1;
        rr_d        = rr_q;
        des_din_d   = des_din_q;
        tx_id_d     = tx_id_q;
        tx_active_d = tx_active_q;
        if (fc_q == FC_GRANT) begin
            if (win_found_s) begin
                des_din_d   = win_data_s;
                tx_id_d     = win_id_s;
                tx_active_d = 1'b1;
                rr_d        = next_rr_ext_s[ID_W-1:0];
            end else begin
                des_din_d   = 64'h0;
                tx_active_d = 1'b0;
            end
        end else begin
            des_din_d   = des_din_q;
            tx_active_d = tx_active_q;
        end
    end

    // Receive FIFO next state: capture on the edge leaving fc==4; a pop on
    // the same edge frees a slot so a full FIFO still accepts the push.
    always_comb begin
        rx_pop_s      = rx_valid_q && bus.rx_ready;
        rx_try_s      = (fc_q == FC_CAPTURE) && bus.rx_enable;
        rx_full_s     = (rx_cnt_q == 2'd2);
        rx_push_s     = rx_try_s && (!rx_full_s || rx_pop_s);
        rx_drop_s     = rx_try_s && rx_full_s && !rx_pop_s;
        rx_cnt_d      = rx_cnt_q;
        rx_mem0_d     = rx_mem0_q;
        rx_mem1_d     = rx_mem1_q;
        rx_drop_cnt_d = rx_drop_cnt_q;
        case ({rx_push_s, rx_pop_s})
            2'b10: begin
                case (rx_cnt_q)
                    2'd0: begin
                        rx_mem0_d = bus.des_dout;
                        rx_cnt_d  = 2'd1;
                    end
                    2'd1: begin
                        rx_mem1_d = bus.des_dout;
                        rx_cnt_d  = 2'd2;
                    end
                    default: begin
                        rx_cnt_d = rx_cnt_q;
                    end
                endcase
            end
            2'b01: begin
                rx_mem0_d = rx_mem1_q;
                rx_cnt_d  = rx_cnt_q - 2'd1;
            end
            2'b11: begin
                // occupancy unchanged; head advances and the new word goes last
                if (rx_cnt_q == 2'd1) begin
                    rx_mem0_d = bus.des_dout;
                end else begin
                    rx_mem0_d = rx_mem1_q;
                    rx_mem1_d = bus.des_dout;
                end
            end
            default: begin
                rx_cnt_d = rx_cnt_q;
            end
        endcase
        rx_valid_d = (rx_cnt_d != 2'd0);
        if (rx_drop_s && (rx_drop_cnt_q != 8'hFF)) begin
            rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
        end else begin
            rx_drop_cnt_d = rx_drop_cnt_q;
        end
    end

    // State registers; reset aborts any frame in flight immediately.
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            fc_q          <= 3'b111;
            rr_q          <= {ID_W{1'b0}};
            des_din_q     <= 64'h0;
            tx_id_q       <= {ID_W{1'b0}};
            tx_active_q   <= 1'b0;
            rx_cnt_q      <= 2'd0;
            rx_mem0_q     <= 64'h0;
            rx_mem1_q     <= 64'h0;
            rx_valid_q    <= 1'b0;
            rx_drop_cnt_q <= 8'h0;
        end else begin
            fc_q          <= fc_d;
            rr_q          <= rr_d;
            des_din_q     <= des_din_d;
            tx_id_q       <= tx_id_d;
            tx_active_q   <= tx_active_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_mem0_q     <= rx_mem0_d;
            rx_mem1_q     <= rx_mem1_d;
            rx_valid_q    <= rx_valid_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.des_din     = des_din_q;
    assign bus.tx_active   = tx_active_q;
    assign bus.tx_id       = tx_id_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_mem0_q;
    assign bus.rx_drop_cnt = rx_drop_cnt_q;

endmodule

// File: tb/tb_des_link_ctrl.sv
// tb_des_link_ctrl
// Directed bench for des_link_ctrl with a frame-level reference model
// (phase number, round-robin pointer, queue-based receive buffer) checked
// against the DUT on every falling edge, plus literal expectations.
module tb_des_link_ctrl;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic in_clk = 1'b0;
    logic rst;

    always #5 in_clk = ~in_clk;

    des_link_ctrl_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    des_link_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .in_clk (in_clk),
        .rst    (rst),
        .bus    (bus)
    );

    // reference model state
    int          fc_m;
    int          rr_m;
    int          id_m;
    int          drop_m;
    logic        act_m;
    logic [63:0] din_m;
    logic [63:0] q_m[$];

    int n_checks = 0;
    int n_err    = 0;
    int grant_log[$];
    int ready_cnt[N_REQ];

    logic [N_REQ-1:0] exp_rdy_c;
    int               w_c;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (rr_m + k) % N_REQ;
            if (bus.req_valid[i] && bus.req_en[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        fc_m   = 7;
        rr_m   = 0;
        id_m   = 0;
        act_m  = 1'b0;
        din_m  = 64'h0;
        drop_m = 0;
        q_m.delete();
    endtask

    // one rising edge of the link, in frame terms
    task automatic model_edge();
        int          w;
        bit          pop;
        bit          push;
        logic [63:0] cap;
        w    = pick_winner();
        pop  = (q_m.size() > 0) && bus.rx_ready;
        push = 1'b0;
        cap  = bus.des_dout;
        if (fc_m == 7) begin
            if (w >= 0) begin
                din_m = bus.req_data[64*w +: 64];
                id_m  = w;
                act_m = 1'b1;
                rr_m  = (w + 1) % N_REQ;
            end else begin
                din_m = 64'h0;
                act_m = 1'b0;
            end
        end
        if (fc_m == 4 && bus.rx_enable) begin
            if (q_m.size() < 2 || pop) push = 1'b1;
            else if (drop_m < 255) drop_m++;
        end
        if (pop)  void'(q_m.pop_front());
        if (push) q_m.push_back(cap);
        fc_m = (fc_m + 1) % 8;
    endtask

    task automatic cycle();
        @(posedge in_clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic wait_fc(input int n);
        int guard;
        guard = 0;
        while (fc_m != n && guard < 32) begin
            cycle();
            guard++;
        end
        if (fc_m != n) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_fc: phase %0d not reached, at %0d", n, fc_m);
        end
    endtask

    task automatic set_data(input int i, input logic [63:0] v);
        bus.req_data[64*i +: 64] = v;
    endtask

    // compare DUT outputs with the model on every falling edge
    always @(negedge in_clk) begin
        w_c       = pick_winner();
        exp_rdy_c = {N_REQ{1'b0}};
        if (!rst && fc_m == 7 && w_c >= 0) exp_rdy_c[w_c] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy_c));
        chk("des_din", bus.des_din, din_m);
        chk("tx_active", 64'(bus.tx_active), 64'(act_m));
        chk("tx_id", 64'(bus.tx_id), 64'(id_m));
        chk("rx_valid", 64'(bus.rx_valid), 64'(q_m.size() > 0));
        if (q_m.size() > 0) chk("rx_data", bus.rx_data, q_m[0]);
        chk("rx_drop_cnt", 64'(bus.rx_drop_cnt), 64'(drop_m));
        for (int k = 0; k < N_REQ; k++) begin
            if (bus.req_ready[k]) begin
                grant_log.push_back(k);
                ready_cnt[k]++;
            end
        end
    end

    initial begin
        logic [63:0] w_words[5];
        int          exp_order[6];
        w_words   = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                      64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                      64'h5555_5555_5555_5555};
        exp_order = '{0, 1, 3, 0, 1, 3};

        rst           = 1'b1;
        bus.req_en    = {N_REQ{1'b0}};
        bus.req_valid = {N_REQ{1'b0}};
        bus.req_data  = {(64*N_REQ){1'b0}};
        bus.des_dout  = 64'h0;
        bus.rx_enable = 1'b0;
        bus.rx_ready  = 1'b0;
        model_reset();
        for (int k = 0; k < N_REQ; k++) ready_cnt[k] = 0;

        // reset values
        #1;
        chk("rst des_din", bus.des_din, 64'h0);
        chk("rst tx_active", 64'(bus.tx_active), 64'h0);
        chk("rst rx_valid", 64'(bus.rx_valid), 64'h0);
        chk("rst rx_data", bus.rx_data, 64'h0);
        chk("rst drop", 64'(bus.rx_drop_cnt), 64'h0);
        repeat (3) cycle();
        rst = 1'b0;

        // idle: two full frames with no requests
        repeat (16) cycle();
        chk("idle grants", 64'(grant_log.size()), 64'd0);
        chk("idle des_din", bus.des_din, 64'h0);

        // single requester 2
        wait_fc(3);
        bus.req_en    = 4'b1111;
        set_data(2, 64'h0123_4567_89AB_CDEF);
        bus.req_valid = 4'b0100;
        wait_fc(0);
        bus.req_valid = 4'b0000;
        chk("single des_din", bus.des_din, 64'h0123_4567_89AB_CDEF);
        chk("single tx_id", 64'(bus.tx_id), 64'd2);
        chk("single tx_active", 64'(bus.tx_active), 64'd1);
        chk("single pulse", 64'(ready_cnt[2]), 64'd1);
        chk("single grants", 64'(grant_log.size()), 64'd1);
        repeat (7) cycle();
        chk("single hold", bus.des_din, 64'h0123_4567_89AB_CDEF);
        cycle();
        chk("single end active", 64'(bus.tx_active), 64'd0);
        chk("single end din", bus.des_din, 64'h0);

        // round-robin with requester 2 masked
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        grant_log.delete();
        for (int k = 0; k < N_REQ; k++) set_data(k, {32'hA5A5_0000, 32'(k)});
        bus.req_valid = 4'b1111;
        bus.req_en    = 4'b1011;
        repeat (48) cycle();
        bus.req_valid = 4'b0000;
        chk("rr count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("rr order", 64'(grant_log[i]), 64'(exp_order[i]));
        end
        chk("rr masked", 64'(ready_cnt[2]), 64'd1);

        // receive path
        bus.rx_enable = 1'b1;
        bus.rx_ready  = 1'b1;
        wait_fc(3);
        bus.des_dout = 64'hDEAD_BEEF_CAFE_F00D;
        wait_fc(5);
        chk("rx valid", 64'(bus.rx_valid), 64'd1);
        chk("rx data", bus.rx_data, 64'hDEAD_BEEF_CAFE_F00D);
        cycle();
        chk("rx popped", 64'(bus.rx_valid), 64'd0);

        // overflow, then simultaneous push/pop on a full FIFO
        bus.rx_ready = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_fc(3);
            bus.des_dout = w_words[f];
            wait_fc(5);
        end
        chk("ovf drop", 64'(bus.rx_drop_cnt), 64'd2);
        chk("ovf head", bus.rx_data, w_words[0]);
        wait_fc(3);
        bus.des_dout = w_words[4];
        wait_fc(4);
        bus.rx_ready = 1'b1;
        cycle();
        bus.rx_ready = 1'b0;
        chk("pushpop drop", 64'(bus.rx_drop_cnt), 64'd2);
        chk("pushpop head", bus.rx_data, w_words[1]);
        bus.rx_enable = 1'b0;
        bus.rx_ready  = 1'b1;
        cycle();
        bus.rx_ready  = 1'b0;
        chk("pushpop tail", bus.rx_data, w_words[4]);

        // reset mid-frame with a frame in flight and one word buffered
        set_data(1, 64'hFEED_FACE_0BAD_C0DE);
        bus.req_valid = 4'b0010;
        bus.req_en    = 4'b1111;
        wait_fc(2);
        chk("pre-rst active", 64'(bus.tx_active), 64'd1);
        chk("pre-rst rx_valid", 64'(bus.rx_valid), 64'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid-rst des_din", bus.des_din, 64'h0);
        chk("mid-rst active", 64'(bus.tx_active), 64'd0);
        chk("mid-rst rx_valid", 64'(bus.rx_valid), 64'd0);
        chk("mid-rst drop", 64'(bus.rx_drop_cnt), 64'd0);
        chk("mid-rst ready", 64'(bus.req_ready), 64'd0);
        cycle();
        cycle();
        rst = 1'b0;
        grant_log.delete();
        set_data(0, 64'h0000_0000_0000_00A0);
        set_data(3, 64'h0000_0000_0000_00A3);
        bus.req_valid = 4'b1011;
        cycle();
        bus.req_valid = 4'b0000;
        chk("restart grants", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) chk("restart winner", 64'(grant_log[0]), 64'd0);
        chk("restart tx_id", 64'(bus.tx_id), 64'd0);
        chk("restart des_din", bus.des_din, 64'h0000_0000_0000_00A0);
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
